// File: rtl/bsg_fsb_pattern_node.sv
// Purpose : FSB loopback test node. It sends numbered byte-pattern packets and checks the returned copies.
// Latency : en_i seen in IDLE gives v_o on the next cycle; status flags are registered and rise 1 cycle after their cause.
// Backpr. : transmit waits on yumi_i and is limited by the credit window; receive is always ready except during reset.
//
// Ports:
//   clk_i, reset_i        node clock; synchronous active-high reset
//   en_i                  FSB node enable; gates transmit only
//   v_i, data_i, ready_o  returned packet stream (into this node)
//   v_o, data_o, yumi_i   transmit packet stream (out of this node)
//   done_o, success_o     run finished / finished cleanly
//   timeout_o, error_o    sticky failure flags
module bsg_fsb_pattern_node #(
    parameter int ring_width_p      = 80,
    parameter int dest_id_p         = 0,
    parameter int num_packets_p     = 16,
    parameter int max_outstanding_p = 4,
    parameter int timeout_p         = 65535
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i,
    output logic                    done_o,
    output logic                    success_o,
    output logic                    timeout_o,
    output logic                    error_o
);

    localparam logic [11:0] NUM_LP  = 12'(num_packets_p);
    localparam logic [3:0]  MAXO_LP = 4'(max_outstanding_p);
    localparam logic [16:0] TO_LP   = 17'(timeout_p);
    localparam logic [3:0]  DEST_LP = 4'(dest_id_p);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Low 76 bits of the packet for sequence number s: {s, 8 incrementing bytes starting at s[7:0]}.
    function automatic logic [75:0] pattern(input logic [11:0] s);
        logic [75:0] p;
        p[75:64] = s;
        for (int c = 0; c < 8; c++) begin
            p[8*c +: 8] = s[7:0] + 8'(c);
        end
        return p;
    endfunction

    state_e      r_state;
    state_e      w_state_nxt;
    logic [11:0] r_tx_cnt;
    logic [11:0] r_rx_cnt;
    logic [3:0]  r_outst;
    logic [15:0] r_to_cnt;
    logic        r_error;
    logic        r_timeout;

    logic        w_run;
    logic        w_v;
    logic        w_tx;
    logic        w_acc;
    logic        w_rx_ok;
    logic        w_mismatch;
    logic        w_err_evt;
    logic        w_complete;
    logic        w_to_clr;
    logic        w_to_fire;
    logic        w_unused_id;

    // The FSB rewrites the id field on the way back, so it never takes part in the compare.
    assign w_unused_id = ^data_i[79:76];

    always_comb begin
        w_run      = (r_state == ST_RUN) & ~reset_i;
        w_v        = w_run & en_i & (r_tx_cnt < NUM_LP) & (r_outst < MAXO_LP);
        w_tx       = yumi_i & w_v;
        w_acc      = v_i & ~reset_i;
        // Only a packet we are actually waiting for advances the receive side.
        w_rx_ok    = w_acc & w_run & (r_outst != 4'd0);
        w_mismatch = (data_i[75:0] != pattern(r_rx_cnt));
        w_err_evt  = w_acc & (~w_run | (r_outst == 4'd0) | w_mismatch);
        w_complete = w_rx_ok & ((r_rx_cnt + 12'd1) == NUM_LP);
        w_to_clr   = w_acc | (r_outst == 4'd0);
        // Completion always carries an accept, which clears the timer; the extra term keeps the priority explicit.
        w_to_fire  = w_run & ~w_to_clr & ~w_complete & (({1'b0, r_to_cnt} + 17'd1) == TO_LP);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (en_i) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_complete || w_to_fire) w_state_nxt = ST_DONE;
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_tx_cnt  <= '0;
            r_rx_cnt  <= '0;
            r_outst   <= '0;
            r_to_cnt  <= '0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_tx) begin
                r_tx_cnt <= r_tx_cnt + 12'd1;
            end
            if (w_rx_ok) begin
                r_rx_cnt <= r_rx_cnt + 12'd1;
            end
            unique case ({w_tx, w_rx_ok})
                2'b10:   r_outst <= r_outst + 4'd1;
                2'b01:   r_outst <= r_outst - 4'd1;
                default: r_outst <= r_outst;
            endcase
            if (w_to_clr) begin
                r_to_cnt <= '0;
            end else if (w_run) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
            r_error   <= r_error | w_err_evt;
            r_timeout <= r_timeout | w_to_fire;
        end
    end

    assign ready_o   = ~reset_i;
    assign v_o       = w_v;
    // Driven to zero whenever nothing is offered so the bus is quiet outside a run.
    assign data_o    = w_v ? {DEST_LP, pattern(r_tx_cnt)} : '0;
    assign done_o    = (r_state == ST_DONE);
    assign success_o = done_o & ~r_error & ~r_timeout;
    assign timeout_o = r_timeout;
    assign error_o   = r_error;

endmodule

// File: tb/tb_bsg_fsb_pattern_node.sv
module tb_bsg_fsb_pattern_node;

    localparam int          NPKT = 16;
    localparam int          MAXO = 4;
    localparam int          TOUT = 100;
    localparam logic [3:0]  DEST = 4'hA;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        en_i = 1'b0;
    logic        v_i = 1'b0;
    logic [79:0] data_i = '0;
    logic        ready_o;
    logic        v_o;
    logic [79:0] data_o;
    logic        yumi_i = 1'b0;
    logic        done_o;
    logic        success_o;
    logic        timeout_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    bsg_fsb_pattern_node #(
        .ring_width_p     (80),
        .dest_id_p        (int'(DEST)),
        .num_packets_p    (NPKT),
        .max_outstanding_p(MAXO),
        .timeout_p        (TOUT)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .en_i     (en_i),
        .v_i      (v_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .yumi_i   (yumi_i),
        .done_o   (done_o),
        .success_o(success_o),
        .timeout_o(timeout_o),
        .error_o  (error_o)
    );

    always #5 clk = ~clk;

    // Loopback environment state.
    int          cyc = 0;
    int          rx_budget = -1;   // -1: unlimited returns; otherwise returns still allowed
    bit          drop_all = 1'b0;
    int          corrupt_idx = -1;
    bit          yumi_en = 1'b1;
    bit          en_val = 1'b0;
    bit          force_rx = 1'b0;
    logic [79:0] force_dat = '0;
    logic [79:0] rq[$];
    int          rq_t[$];
    logic [79:0] tx_data[$];
    int          tx_cyc[$];
    int          rx_idx = 0;
    int          rx_cyc_last = 0;
    int          bad_cyc = -1;

    // Expected packet for sequence number s, straight from the packet format rules.
    function automatic logic [79:0] ref_pkt(input int s);
        logic [79:0] p;
        p = '0;
        p[79:76] = DEST;
        p[75:64] = 12'(s % 4096);
        for (int c = 0; c < 8; c++) begin
            p[8*c +: 8] = 8'((s + c) % 256);
        end
        return p;
    endfunction

    // One cycle of the board loopback: inputs change at negedge, the DUT samples at the next posedge.
    task automatic step();
        @(negedge clk);
        cyc++;
        en_i   = en_val;
        v_i    = 1'b0;
        data_i = '0;
        if (force_rx) begin
            v_i    = 1'b1;
            data_i = force_dat;
        end else if (rx_budget != 0 && rq.size() > 0 && rq_t[0] <= cyc) begin
            v_i    = 1'b1;
            data_i = rq[0];
            data_i[79:76] = 4'h0;
            if (rx_idx == corrupt_idx) data_i[10] = ~data_i[10];
        end
        #1;
        yumi_i = yumi_en & v_o;
        if (yumi_i) begin
            tx_data.push_back(data_o);
            tx_cyc.push_back(cyc);
            if (!drop_all) begin
                rq.push_back(data_o);
                rq_t.push_back(cyc + int'($urandom_range(1, 5)));
            end
        end
        if (v_i && ready_o && !force_rx) begin
            rq.delete(0);
            rq_t.delete(0);
            if (rx_idx == corrupt_idx) bad_cyc = cyc;
            rx_idx++;
            rx_cyc_last = cyc;
            if (rx_budget > 0) rx_budget--;
        end
    endtask

    task automatic bench_reset();
        @(negedge clk);
        reset_i = 1'b1;
        en_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        rq.delete(); rq_t.delete(); tx_data.delete(); tx_cyc.delete();
        rx_idx = 0; rx_cyc_last = 0; bad_cyc = -1;
        rx_budget = -1; drop_all = 1'b0; corrupt_idx = -1;
        yumi_en = 1'b1; en_val = 1'b0; force_rx = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
        checks++; if (data_o !== 80'h0) begin errors++; $display("FAIL reset_data_o got=%h exp=0", data_o); end
        checks++; if ({done_o, success_o, timeout_o, error_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {done_o, success_o, timeout_o, error_o});
        end
        reset_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", ready_o); end
    endtask

    task automatic test_ideal_loopback();
        int n;
        int done_cyc;
        bit vo_seen_low;
        bench_reset();
        en_val = 1'b1;
        step();
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL idle_first_en_v_o got=%b exp=0", v_o); end
        step();
        checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL en_plus1_v_o got=%b exp=1", v_o); end
        n = 0; done_cyc = -1; vo_seen_low = 1'b0;
        while (n < 600 && done_o !== 1'b1) begin
            step();
            n++;
            if (tx_data.size() == NPKT && cyc == tx_cyc[NPKT-1] + 1) vo_seen_low = (v_o === 1'b0);
            if (done_o === 1'b1) done_cyc = cyc;
        end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL ideal_done got=%b exp=1 after %0d cycles", done_o, n); end
        checks++; if (success_o !== 1'b1 || error_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++; $display("FAIL ideal_status succ=%b err=%b to=%b exp=1,0,0", success_o, error_o, timeout_o);
        end
        checks++; if (tx_data.size() != NPKT) begin errors++; $display("FAIL ideal_tx_count got=%0d exp=%0d", tx_data.size(), NPKT); end
        for (int i = 0; i < NPKT && i < tx_data.size(); i++) begin
            checks++;
            if (tx_data[i] !== ref_pkt(i)) begin errors++; $display("FAIL ideal_pkt%0d got=%h exp=%h", i, tx_data[i], ref_pkt(i)); end
        end
        if (tx_data.size() > 3) begin
            checks++;
            if (tx_data[3][63:0] !== 64'h0A09080706050403) begin
                errors++; $display("FAIL pkt3_payload got=%h exp=0a09080706050403", tx_data[3][63:0]);
            end
        end
        checks++; if (vo_seen_low !== 1'b1) begin errors++; $display("FAIL final_yumi_drops_v_o got=%b exp=1", vo_seen_low); end
        checks++; if (done_cyc != rx_cyc_last + 1) begin
            errors++; $display("FAIL done_latency got=cycle %0d exp=cycle %0d", done_cyc, rx_cyc_last + 1);
        end
    endtask

    task automatic test_credit_limit();
        int n;
        int k;
        bench_reset();
        rx_budget = 0;
        en_val = 1'b1;
        repeat (12) step();
        checks++; if (tx_data.size() != MAXO) begin errors++; $display("FAIL credit_yumis got=%0d exp=%0d", tx_data.size(), MAXO); end
        if (tx_data.size() >= MAXO) begin
            checks++;
            if (tx_cyc[MAXO-1] - tx_cyc[0] != MAXO - 1) begin
                errors++; $display("FAIL credit_back_to_back got=%0d exp=%0d", tx_cyc[MAXO-1] - tx_cyc[0], MAXO - 1);
            end
        end
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL credit_v_o_low got=%b exp=0", v_o); end
        rx_budget = 1;
        n = 0;
        while (n < 20 && rx_idx == 0) begin step(); n++; end
        k = rx_cyc_last;
        step();
        checks++; if (rx_idx != 1 || cyc != k + 1 || v_o !== 1'b1) begin
            errors++; $display("FAIL credit_release_v_o got=%b exp=1 (returns=%0d)", v_o, rx_idx);
        end
        rx_budget = -1;
        n = 0;
        while (n < 600 && done_o !== 1'b1) begin step(); n++; end
        checks++; if (success_o !== 1'b1 || tx_data.size() != NPKT) begin
            errors++; $display("FAIL credit_completion succ=%b tx=%0d exp=1,%0d", success_o, tx_data.size(), NPKT);
        end
    endtask

    task automatic test_corruption();
        int n;
        int err_cyc;
        bench_reset();
        corrupt_idx = 5;
        en_val = 1'b1;
        n = 0; err_cyc = -1;
        while (n < 600 && done_o !== 1'b1) begin
            step();
            n++;
            if (error_o === 1'b1 && err_cyc < 0) err_cyc = cyc;
        end
        checks++; if (bad_cyc < 0 || err_cyc != bad_cyc + 1) begin
            errors++; $display("FAIL corrupt_error_latency got=cycle %0d exp=cycle %0d", err_cyc, bad_cyc + 1);
        end
        checks++; if (done_o !== 1'b1 || success_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++; $display("FAIL corrupt_status done=%b succ=%b to=%b exp=1,0,0", done_o, success_o, timeout_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        int to_cyc;
        bench_reset();
        drop_all = 1'b1;
        en_val = 1'b1;
        n = 0; to_cyc = -1;
        while (n < 400 && done_o !== 1'b1) begin
            step();
            n++;
            if (timeout_o === 1'b1 && to_cyc < 0) to_cyc = cyc;
        end
        // The first packet leaves at the edge ending its yumi cycle; TOUT clocks later timeout_o
        // rises, which is first visible in the cycle TOUT+1 after the yumi cycle.
        checks++; if (tx_cyc.size() == 0 || to_cyc != tx_cyc[0] + TOUT + 1) begin
            errors++; $display("FAIL timeout_latency got=cycle %0d exp=cycle %0d", to_cyc, (tx_cyc.size() > 0) ? tx_cyc[0] + TOUT + 1 : -1);
        end
        checks++; if (done_o !== 1'b1 || timeout_o !== 1'b1 || success_o !== 1'b0 || error_o !== 1'b0) begin
            errors++; $display("FAIL timeout_status done=%b to=%b succ=%b err=%b exp=1,1,0,0", done_o, timeout_o, success_o, error_o);
        end
        checks++; if (tx_data.size() != MAXO) begin errors++; $display("FAIL timeout_tx_count got=%0d exp=%0d", tx_data.size(), MAXO); end
    endtask

    task automatic test_en_gap();
        int n;
        int bad_v;
        int bad_seq;
        int sz;
        bench_reset();
        en_val = 1'b1;
        n = 0;
        while (n < 60 && tx_data.size() < 5) begin step(); n++; end
        sz = tx_data.size();
        en_val = 1'b0;
        bad_v = 0;
        repeat (20) begin
            step();
            if (v_o !== 1'b0) bad_v++;
        end
        checks++; if (bad_v != 0 || tx_data.size() != sz) begin
            errors++; $display("FAIL en_gap_quiet got=%0d v_o cycles, %0d new pkts exp=0,0", bad_v, tx_data.size() - sz);
        end
        en_val = 1'b1;
        n = 0;
        while (n < 600 && done_o !== 1'b1) begin step(); n++; end
        bad_seq = 0;
        for (int i = 0; i < tx_data.size(); i++) begin
            if (int'(tx_data[i][75:64]) != i) bad_seq++;
        end
        checks++; if (bad_seq != 0 || tx_data.size() != NPKT) begin
            errors++; $display("FAIL en_gap_sequence got=%0d bad of %0d exp=0 of %0d", bad_seq, tx_data.size(), NPKT);
        end
        checks++; if (success_o !== 1'b1) begin errors++; $display("FAIL en_gap_success got=%b exp=1", success_o); end
    endtask

    task automatic test_reset_midrun();
        int n;
        int unstable;
        bench_reset();
        en_val = 1'b1;
        n = 0;
        while (n < 60 && tx_data.size() < 7) begin step(); n++; end
        @(negedge clk);
        reset_i = 1'b1;
        en_i = 1'b0; yumi_i = 1'b0;
        v_i = 1'b1;
        data_i = ref_pkt(0);
        data_i[79:76] = 4'h0;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL midrun_reset_ready got=%b exp=0", ready_o); end
        @(negedge clk);
        #1;
        checks++; if (v_o !== 1'b0 || data_o !== 80'h0 || ready_o !== 1'b0) begin
            errors++; $display("FAIL midrun_reset_outputs v_o=%b data=%h ready=%b exp=0,0,0", v_o, data_o, ready_o);
        end
        checks++; if ({done_o, success_o, timeout_o, error_o} !== 4'b0000) begin
            errors++; $display("FAIL midrun_reset_flags got=%b exp=0000", {done_o, success_o, timeout_o, error_o});
        end
        reset_i = 1'b0;
        v_i = 1'b0;
        rq.delete(); rq_t.delete(); tx_data.delete(); tx_cyc.delete(); rx_idx = 0;
        yumi_en = 1'b0;
        en_val = 1'b1;
        step();
        step();
        checks++; if (v_o !== 1'b1 || data_o !== ref_pkt(0)) begin
            errors++; $display("FAIL restart_seq0 v_o=%b data=%h exp=1,%h", v_o, data_o, ref_pkt(0));
        end
        unstable = 0;
        repeat (3) begin
            step();
            if (v_o !== 1'b1 || data_o !== ref_pkt(0)) unstable++;
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL hold_stable got=%0d changes exp=0", unstable); end
        force_dat = ref_pkt(0);
        force_dat[79:76] = 4'h0;
        force_rx = 1'b1;
        step();
        force_rx = 1'b0;
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL unsolicited_pre got=%b exp=0", error_o); end
        step();
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL unsolicited_error got=%b exp=1", error_o); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=time limit exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ideal_loopback();
        test_credit_limit();
        test_corruption();
        test_timeout();
        test_en_gap();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
